// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle between the FIFO consumer and its pointer/flag
// controller.
interface fifo_rd_ctrl_if #(
    parameter int PTR_WIDTH  = 4,
    parameter int ADDR_WIDTH = 3
);
    logic                  rinc;
    logic [PTR_WIDTH-1:0]  rq2_wptr;
    logic                  clr_underflow;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PTR_WIDTH-1:0]  rptr;
    logic                  rempty;
    logic                  raempty;
    logic [PTR_WIDTH-1:0]  rcount;
    logic                  runderflow;

    modport master (
        output rinc,
        output rq2_wptr,
        output clr_underflow,
        input  raddr,
        input  rptr,
        input  rempty,
        input  raempty,
        input  rcount,
        input  runderflow
    );

    modport slave (
        input  rinc,
        input  rq2_wptr,
        input  clr_underflow,
        output raddr,
        output rptr,
        output rempty,
        output raempty,
        output rcount,
        output runderflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: binary/Gray read pointer, empty,
// almost-empty, occupancy and sticky underflow, all registered.
module fifo_rd_ctrl #(
    parameter int PTR_WIDTH     = 4,
    parameter int ADDR_WIDTH    = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_rd_ctrl_if.slave  bus
);
    localparam logic [PTR_WIDTH-1:0] AE_TH =
        PTR_WIDTH'(AEMPTY_THRESH);

    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] rbin_next;
    logic [PTR_WIDTH-1:0] gray_next;
    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] diff;
    logic [PTR_WIDTH-1:0] rptr_q;
    logic [PTR_WIDTH-1:0] rcount_q;
    logic                 rempty_q;
    logic                 raempty_q;
    logic                 under_q;
    logic                 accept;
    logic                 under_set;

    assign accept    = bus.rinc & ~rempty_q;
    assign under_set = bus.rinc & rempty_q;
    assign rbin_next = rbin + PTR_WIDTH'(accept);
    assign gray_next = rbin_next ^ (rbin_next >> 1);

    // Bit i of the binary value is the XOR of all Gray bits at and above i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    assign diff = wbin - rbin_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin      <= '0;
            rptr_q    <= '0;
            rcount_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            under_q   <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            rptr_q    <= gray_next;
            rcount_q  <= diff;
            rempty_q  <= (gray_next == bus.rq2_wptr);
            raempty_q <= (diff <= AE_TH);
            under_q   <= under_set | (under_q & ~bus.clr_underflow);
        end
    end

    assign bus.raddr      = rbin[ADDR_WIDTH-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rcount     = rcount_q;
    assign bus.rempty     = rempty_q;
    assign bus.raempty    = raempty_q;
    assign bus.runderflow = under_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: reset, reads to empty, underflow,
// pointer wrap, concurrent read/write-pointer update, mid-burst reset.
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.PTR_WIDTH(4), .ADDR_WIDTH(3)) bus ();

    fifo_rd_ctrl #(
        .PTR_WIDTH(4),
        .ADDR_WIDTH(3),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] a,
                          input logic [3:0] p, input logic e,
                          input logic ae, input logic [3:0] c,
                          input logic u);
        chk({tag, ".raddr"}, 8'(bus.raddr), 8'(a));
        chk({tag, ".rptr"}, 8'(bus.rptr), 8'(p));
        chk({tag, ".rempty"}, 8'(bus.rempty), 8'(e));
        chk({tag, ".raempty"}, 8'(bus.raempty), 8'(ae));
        chk({tag, ".rcount"}, 8'(bus.rcount), 8'(c));
        chk({tag, ".runderflow"}, 8'(bus.runderflow), 8'(u));
        checks++;
        assert (bus.rcount <= 4'd8) else begin
            errors++;
            $error("FAIL %s.range observed=%0d expected<=8",
                   tag, bus.rcount);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rinc          = 1'b0;
        bus.rq2_wptr      = 4'b0000;
        bus.clr_underflow = 1'b0;

        // 1: async reset, no clock edge yet
        #1 rst = 1'b1;
        #1;
        chk_st("rst0", 3'd0, 4'b0000, 1, 1, 4'd0, 0);
        tick();
        tick();
        rst = 1'b0;

        // 2: three entries, read to empty
        bus.rq2_wptr = 4'b0010;
        tick();
        chk_st("fill3", 3'd0, 4'b0000, 0, 0, 4'd3, 0);
        bus.rinc = 1'b1;
        tick();
        chk_st("rd1", 3'd1, 4'b0001, 0, 0, 4'd2, 0);
        tick();
        chk_st("rd2", 3'd2, 4'b0011, 0, 1, 4'd1, 0);
        tick();
        chk_st("rd3", 3'd3, 4'b0010, 1, 1, 4'd0, 0);

        // 3: underflow, hold, clear, set-beats-clear
        tick();
        chk_st("uf_set", 3'd3, 4'b0010, 1, 1, 4'd0, 1);
        bus.rinc = 1'b0;
        tick();
        chk_st("uf_hold", 3'd3, 4'b0010, 1, 1, 4'd0, 1);
        bus.clr_underflow = 1'b1;
        tick();
        chk_st("uf_clr", 3'd3, 4'b0010, 1, 1, 4'd0, 0);
        bus.rinc = 1'b1;
        tick();
        chk_st("uf_both", 3'd3, 4'b0010, 1, 1, 4'd0, 1);
        bus.rinc          = 1'b0;
        bus.clr_underflow = 1'b0;

        // 4: wrap through full depth twice
        #2 rst = 1'b1;
        #1;
        chk_st("rst1", 3'd0, 4'b0000, 1, 1, 4'd0, 0);
        rst = 1'b0;
        bus.rq2_wptr = 4'b1100;
        tick();
        chk_st("full", 3'd0, 4'b0000, 0, 0, 4'd8, 0);
        bus.rinc = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk_st("wrap7", 3'd7, 4'b0100, 0, 1, 4'd1, 0);
        tick();
        bus.rinc = 1'b0;
        chk_st("wrap8", 3'd0, 4'b1100, 1, 1, 4'd0, 0);
        bus.rq2_wptr = 4'b0000;
        tick();
        chk_st("full2", 3'd0, 4'b1100, 0, 0, 4'd8, 0);
        bus.rinc = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk_st("wrap15", 3'd7, 4'b1000, 0, 1, 4'd1, 0);
        tick();
        bus.rinc = 1'b0;
        chk_st("wrap16", 3'd0, 4'b0000, 1, 1, 4'd0, 0);

        // 5: write pointer moves in the same cycle as a read
        bus.rq2_wptr = 4'b0101;
        tick();
        chk_st("fill6", 3'd0, 4'b0000, 0, 0, 4'd6, 0);
        bus.rinc = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk_st("rbin5", 3'd5, 4'b0111, 0, 1, 4'd1, 0);
        bus.rq2_wptr = 4'b0100;
        tick();
        bus.rinc = 1'b0;
        chk_st("simul", 3'd6, 4'b0101, 0, 1, 4'd1, 0);

        // 6: async reset mid-burst
        bus.rq2_wptr = 4'b1110;
        tick();
        chk_st("fill5", 3'd6, 4'b0101, 0, 0, 4'd5, 0);
        bus.rinc = 1'b1;
        tick();
        chk_st("burst", 3'd7, 4'b0100, 0, 0, 4'd4, 0);
        #3 rst = 1'b1;
        #1;
        chk_st("rst_mid", 3'd0, 4'b0000, 1, 1, 4'd0, 0);
        #1 rst = 1'b0;
        bus.rinc     = 1'b0;
        bus.rq2_wptr = 4'b0000;
        tick();
        chk_st("post1", 3'd0, 4'b0000, 1, 1, 4'd0, 0);
        tick();
        chk_st("post2", 3'd0, 4'b0000, 1, 1, 4'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
